// File: rtl/control_unit.sv
// Multi-cycle Moore controller for the RV32I subset CPU: sequences memory, ALU muxes, reg write, PC update.
// Optional TRAP_ILLEGAL_EN: unknown opcodes halt with illegal=1 instead of executing as a nop.
module control_unit #(
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [6:0]               opcode,
  input  logic                     zero,
  input  logic                     mem_ready,
  output logic                     mem_valid,
  output logic                     mem_write,
  output logic                     adr_src,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     reg_write,
  output logic [1:0]               result_src,
  output logic [1:0]               alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               alu_op,
  output logic [INSTRET_WIDTH-1:0] instret,
  output logic                     illegal
);

  // state    | meaning
  // IDLE     | one cycle after reset, all outputs low
  // FETCH    | read instruction at PC, PC+4 -> PC on mem_ready
  // DECODE   | branch target into ALUOut, dispatch on opcode
  // MEMADR   | rs1 + imm address for lw/sw
  // MEMREAD  | load access, held until mem_ready
  // MEMWB    | write load data to rd
  // MEMWRITE | store access, held until mem_ready
  // EXECR    | rs1 op rs2
  // EXECI    | rs1 op imm
  // ALUWB    | write ALUOut to rd
  // BRANCH   | rs1 - rs2, take branch on zero
  // JAL      | PC <- target, ALUOut <- old PC + 4
  // AUIPC    | old PC + imm
  // LUIWB    | write immediate to rd
  // HALT     | illegal opcode trap, left only by reset
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECR    = 4'd7,
    EXECI    = 4'd8,
    ALUWB    = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    AUIPC    = 4'd12,
    LUIWB    = 4'd13,
    HALT     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t state, state_next;
  logic   pc_update, branch;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      instret <= '0;
    end else begin
      state <= state_next;
      // Retire on every return to FETCH from a real instruction state.
      if (state_next == FETCH && state != IDLE && state != FETCH)
        instret <= instret + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    unique case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        mem_valid  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_R:              state_next = EXECR;
          OP_I:              state_next = EXECI;
          OP_BR:             state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_AUIPC:          state_next = AUIPC;
          OP_LUI:            state_next = LUIWB;
`ifdef TRAP_ILLEGAL_EN
          default:           state_next = HALT;
`else
          default:           state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_valid = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        mem_valid = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      AUIPC: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      LUIWB: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
`ifdef TRAP_ILLEGAL_EN
      HALT: illegal = 1'b1;
`endif
      default: state_next = IDLE;
    endcase
  end

  assign pc_write = pc_update | (branch & zero);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle output vectors, instret counting and wrap, async reset.
module tb_control_unit;
  localparam int IW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [6:0]    opcode = 7'h00;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_valid, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
  logic [IW-1:0] instret;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  control_unit #(.INSTRET_WIDTH(IW)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instret(instret), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // {mem_valid,mem_write,adr_src,ir_write,pc_write,reg_write} {result_src,alu_src_a,alu_src_b,alu_op} {illegal}
  localparam logic [14:0] V_IDLE  = 15'b0;
  localparam logic [14:0] V_FRDY  = {6'b100110, 8'b10_00_10_00, 1'b0};
  localparam logic [14:0] V_FWAIT = {6'b100000, 8'b10_00_10_00, 1'b0};
  localparam logic [14:0] V_DEC   = {6'b000000, 8'b00_01_01_00, 1'b0};
  localparam logic [14:0] V_MADR  = {6'b000000, 8'b00_10_01_00, 1'b0};
  localparam logic [14:0] V_MRD   = {6'b101000, 8'b00_00_00_00, 1'b0};
  localparam logic [14:0] V_MWB   = {6'b000001, 8'b01_00_00_00, 1'b0};
  localparam logic [14:0] V_MWR   = {6'b111000, 8'b00_00_00_00, 1'b0};
  localparam logic [14:0] V_EXR   = {6'b000000, 8'b00_10_00_10, 1'b0};
  localparam logic [14:0] V_EXI   = {6'b000000, 8'b00_10_01_10, 1'b0};
  localparam logic [14:0] V_AUI   = {6'b000000, 8'b00_01_01_00, 1'b0};
  localparam logic [14:0] V_ALUWB = {6'b000001, 8'b00_00_00_00, 1'b0};
  localparam logic [14:0] V_BRT   = {6'b000010, 8'b00_10_00_01, 1'b0};
  localparam logic [14:0] V_BRN   = {6'b000000, 8'b00_10_00_01, 1'b0};
  localparam logic [14:0] V_JAL   = {6'b000010, 8'b00_01_10_00, 1'b0};
  localparam logic [14:0] V_LUI   = {6'b000001, 8'b11_00_00_00, 1'b0};
  localparam logic [14:0] V_HALT  = {6'b000000, 8'b00_00_00_00, 1'b1};

  wire [14:0] outs = {mem_valid, mem_write, adr_src, ir_write, pc_write, reg_write,
                      result_src, alu_src_a, alu_src_b, alu_op, illegal};

  task automatic chk(input string tag, input logic [14:0] exp);
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s outs=%b expected=%b", tag, outs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [IW-1:0] e;
    e = IW'(exp_cnt);
    checks++;
    assert (instret === e) else begin
      errors++;
      $error("FAIL %s instret=%0d expected=%0d", tag, instret, e);
    end
  endtask

  // Drive mem_ready for the current state, check its outputs, then advance one clock.
  task automatic cyc(input string tag, input logic rdy, input logic [14:0] exp);
    mem_ready = rdy;
    #1;
    chk(tag, exp);
    @(posedge clock);
    #1;
  endtask

  task automatic retire();
    exp_cnt = (exp_cnt + 1) % (1 << IW);
  endtask

  initial begin
    #12;
    chk("in_reset", V_IDLE);
    chk_cnt("in_reset_cnt");
    reset_n = 1'b1;
    cyc("idle", 1'b0, V_IDLE);

    // add x0,x1,x2
    opcode = 7'h33;
    cyc("add_fetch", 1'b1, V_FRDY);
    cyc("add_dec", 1'b0, V_DEC);
    cyc("add_exec", 1'b0, V_EXR);
    cyc("add_wb", 1'b0, V_ALUWB);
    retire();
    chk_cnt("add_cnt");

    // lw with one fetch wait and three data wait states
    opcode = 7'h03;
    cyc("lw_fwait", 1'b0, V_FWAIT);
    cyc("lw_fetch", 1'b1, V_FRDY);
    cyc("lw_dec", 1'b0, V_DEC);
    cyc("lw_adr", 1'b0, V_MADR);
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 1'b0, V_MRD);
    cyc("lw_rd", 1'b1, V_MRD);
    cyc("lw_wb", 1'b0, V_MWB);
    retire();
    chk_cnt("lw_cnt");

    // sw with one wait state
    opcode = 7'h23;
    cyc("sw_fetch", 1'b1, V_FRDY);
    cyc("sw_dec", 1'b0, V_DEC);
    cyc("sw_adr", 1'b0, V_MADR);
    cyc("sw_wr_wait", 1'b0, V_MWR);
    cyc("sw_wr", 1'b1, V_MWR);
    retire();
    chk_cnt("sw_cnt");

    // beq taken then not taken
    opcode = 7'h63;
    cyc("beqt_fetch", 1'b1, V_FRDY);
    cyc("beqt_dec", 1'b0, V_DEC);
    zero = 1'b1;
    cyc("beqt_br", 1'b0, V_BRT);
    zero = 1'b0;
    retire();
    chk_cnt("beqt_cnt");
    cyc("beqn_fetch", 1'b1, V_FRDY);
    cyc("beqn_dec", 1'b0, V_DEC);
    cyc("beqn_br", 1'b0, V_BRN);
    retire();
    chk_cnt("beqn_cnt");

    opcode = 7'h13;
    cyc("addi_fetch", 1'b1, V_FRDY);
    cyc("addi_dec", 1'b0, V_DEC);
    cyc("addi_exec", 1'b0, V_EXI);
    cyc("addi_wb", 1'b0, V_ALUWB);
    retire();
    opcode = 7'h17;
    cyc("auipc_fetch", 1'b1, V_FRDY);
    cyc("auipc_dec", 1'b0, V_DEC);
    cyc("auipc_exec", 1'b0, V_AUI);
    cyc("auipc_wb", 1'b0, V_ALUWB);
    retire();
    opcode = 7'h37;
    cyc("lui_fetch", 1'b1, V_FRDY);
    cyc("lui_dec", 1'b0, V_DEC);
    cyc("lui_wb", 1'b0, V_LUI);
    retire();
    chk_cnt("lui_cnt");

    // async reset in the middle of a load access
    opcode = 7'h03;
    cyc("rst_fetch", 1'b1, V_FRDY);
    cyc("rst_dec", 1'b0, V_DEC);
    cyc("rst_adr", 1'b0, V_MADR);
    mem_ready = 1'b0;
    #1;
    chk("rst_mrd", V_MRD);
    reset_n = 1'b0;
    #1;
    chk("rst_drop", V_IDLE);
    exp_cnt = 0;
    chk_cnt("rst_cnt");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc("rst_idle", 1'b0, V_IDLE);
    chk("rst_fetch_after", V_FWAIT);
    chk_cnt("rst_cnt_after");

    // unknown opcode
    opcode = 7'h7F;
    cyc("ill_fetch", 1'b1, V_FRDY);
    cyc("ill_dec", 1'b0, V_DEC);
`ifdef TRAP_ILLEGAL_EN
    for (int i = 0; i < 3; i++) cyc("ill_halt", 1'b1, V_HALT);
    chk_cnt("ill_cnt");
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    exp_cnt = 0;
    cyc("ill_idle", 1'b0, V_IDLE);
`else
    retire();
    chk("ill_nop_fetch", V_FWAIT);
    chk_cnt("ill_cnt");
`endif

    // bring counter to its max, then a jal must wrap it to 0
    opcode = 7'h13;
    for (int n = 0; n < 16 && exp_cnt != (1 << IW) - 1; n++) begin
      cyc("fill_fetch", 1'b1, V_FRDY);
      cyc("fill_dec", 1'b0, V_DEC);
      cyc("fill_exec", 1'b0, V_EXI);
      cyc("fill_wb", 1'b0, V_ALUWB);
      retire();
    end
    chk_cnt("max_cnt");
    opcode = 7'h6F;
    cyc("jal_fetch", 1'b1, V_FRDY);
    cyc("jal_dec", 1'b0, V_DEC);
    cyc("jal_jal", 1'b0, V_JAL);
    cyc("jal_wb", 1'b0, V_ALUWB);
    retire();
    chk_cnt("jal_wrap_cnt");
    chk("jal_next_fetch", V_FWAIT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
